sub_multicycle: RTL
===================

// Module: sub_multicycle
//
// PURPOSE
// Multi-cycle ripple-borrow subtractor: computes in0 - in1 - borrow_in over
// WIDTH/CHUNK_WIDTH clock cycles, one CHUNK_WIDTH slice per cycle, LSB first.
// Companion to the combinational add family. Used where a full-width
// subtractor does not meet timing. Produces diff, borrow_out and signed overflow.
// Uses a go/done handshake.
//
// PARAMETERS
// WIDTH        16  operand/result width in bits; must be >= 1
// CHUNK_WIDTH   4  bits processed per cycle; WIDTH % CHUNK_WIDTH must be 0
//                  (elaboration-time $fatal otherwise). NUM_CHUNKS = WIDTH/CHUNK_WIDTH.
//
// PORTS
// clk         in   1      clock; all state updates on rising edge
// rst         in   1      synchronous reset, active high
// go          in   1      start request; sampled only in IDLE or DONE
// in0         in   WIDTH  minuend, unsigned or two's complement
// in1         in   WIDTH  subtrahend
// borrow_in   in   1      borrow into bit 0
// diff        out  WIDTH  (in0 - in1 - borrow_in) mod 2**WIDTH; valid while done=1
// borrow_out  out  1      1 iff in0 < in1 + borrow_in (unsigned); valid while done=1
// overflow    out  1      signed overflow; valid while done=1
// done        out  1      result valid; held until next accepted go
//
// BEHAVIOUR
// - Reset: state=IDLE; done=0, diff=0, borrow_out=0, overflow=0. All internal
//   registers are cleared. Reset mid-COMPUTE aborts the operation.
// - FSM states: IDLE, COMPUTE, DONE.
//   - IDLE/DONE -> COMPUTE when go=1. in0, in1 and borrow_in are latched on
//     that edge. Chunk index is set to 0. done is cleared on that edge.
//   - COMPUTE: each edge processes chunk i as
//     {c, d[i]} = a[i] + ~b[i] + c_prev.
//     The initial c_prev is ~borrow_in. i increments on each edge.
//   - COMPUTE -> DONE on the edge that processes chunk NUM_CHUNKS-1.
//     On that edge, done goes to 1 and borrow_out = ~final carry.
//   - DONE: outputs hold; go=1 restarts immediately (back-to-back allowed).
// - Latency: go sampled at edge k -> done=1 after edge k+NUM_CHUNKS.
//   Throughput is one result per NUM_CHUNKS cycles.
// - go in COMPUTE is ignored; no queuing. Input changes after the latching
//   edge have no effect on the result.
// - diff, borrow_out and overflow may change during COMPUTE; they are valid
//   only when done=1.
// - overflow = (in0[MSB] != in1[MSB]) && (diff[MSB] != in0[MSB]),
//   using the latched operands.
// - NUM_CHUNKS=1: the operation completes in one cycle; the FSM is unchanged.
//
// TESTING (WIDTH=16, CHUNK_WIDTH=4 unless noted)
// 1. Assert rst 2 cycles, go=0 -> done=0, diff=0, borrow_out=0, overflow=0.
// 2. go with in0=0x0005, in1=0x0003, bin=0 -> done exactly 4 cycles later;
//    diff=0x0002, borrow_out=0, overflow=0.
// 3. in0=0x0000, in1=0x0001, bin=0 -> diff=0xFFFF, borrow_out=1, overflow=0.
//    in0=0x1234, in1=0x1234, bin=1 -> diff=0xFFFF, borrow_out=1, overflow=0.
// 4. in0=0x8000, in1=0x0001 -> diff=0x7FFF, borrow_out=0, overflow=1.
//    in0=0x7FFF, in1=0xFFFF -> diff=0x8000, borrow_out=1, overflow=1.
// 5. Pulse go again and change in0/in1 mid-COMPUTE -> result unchanged, done
//    timing unchanged. Assert rst mid-COMPUTE -> done=0 and outputs=0 next
//    cycle; no done pulse follows.
// 6. Run 1000 random back-to-back ops (go held high in DONE), also with
//    CHUNK_WIDTH=1 and CHUNK_WIDTH=16. Compare against the model
//    {c, d} = {1'b0, in0} - in1 - bin, with borrow_out=c.

Source files
------------

// File: rtl/sub_multicycle.sv
// Multi-cycle ripple-borrow subtractor: in0 - in1 - borrow_in computed one
// CHUNK_WIDTH slice per clock, LSB first, with a go/done handshake.
module sub_multicycle #(
    parameter int WIDTH       = 16,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             done
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    generate
        if (WIDTH < 1 || CHUNK_WIDTH < 1 || (WIDTH % CHUNK_WIDTH) != 0) begin : g_param_check
            $fatal(1, "sub_multicycle: WIDTH must be a positive multiple of CHUNK_WIDTH");
        end
    endgenerate

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } operand_t;

    logic [1:0]             state;
    logic [IDX_W-1:0]       idx_q;
    operand_t               opnd_q;
    logic                   carry_q;

    logic [CHUNK_WIDTH-1:0] a_chunk;
    logic [CHUNK_WIDTH-1:0] b_chunk;
    logic [CHUNK_WIDTH:0]   chunk_sum;
    logic [WIDTH+CHUNK_WIDTH-1:0] diff_shift;
    logic                   last_chunk;

    // Subtraction as a + ~b + carry, where the carry is an inverted borrow.
    always_comb begin
        a_chunk    = CHUNK_WIDTH'(opnd_q.a >> (idx_q * CHUNK_WIDTH));
        b_chunk    = CHUNK_WIDTH'(opnd_q.b >> (idx_q * CHUNK_WIDTH));
        chunk_sum  = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK_WIDTH{1'b0}}, carry_q};
        diff_shift = {chunk_sum[CHUNK_WIDTH-1:0], diff};
        last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx_q      <= '0;
            opnd_q     <= '0;
            carry_q    <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        opnd_q  <= '{a: in0, b: in1};
                        carry_q <= ~borrow_in;
                        idx_q   <= '0;
                        done    <= 1'b0;
                        state   <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    // Result slices enter at the top and shift down; after the
                    // last chunk the LSB slice has reached bit 0.
                    diff    <= diff_shift[WIDTH+CHUNK_WIDTH-1:CHUNK_WIDTH];
                    carry_q <= chunk_sum[CHUNK_WIDTH];
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_chunk) begin
                        state      <= S_DONE;
                        done       <= 1'b1;
                        borrow_out <= ~chunk_sum[CHUNK_WIDTH];
                        overflow   <= (opnd_q.a[WIDTH-1] != opnd_q.b[WIDTH-1]) &&
                                      (chunk_sum[CHUNK_WIDTH-1] != opnd_q.a[WIDTH-1]);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
